// File: rtl/cndm_proto_tx_sched.sv
// cndm_proto_tx_sched: round-robin transmit scheduler tracking per-queue pending
// descriptors and issuing one request per queue up to a global in-flight limit.
module cndm_proto_tx_sched #(
  parameter int QUEUES       = 4,
  parameter int QUEUE_IDX_W  = $clog2(QUEUES),
  parameter int CNT_W        = 16,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [QUEUES-1:0]                  enable,
  input  logic                               db_valid,
  input  logic [QUEUE_IDX_W-1:0]             db_queue,
  input  logic [CNT_W-1:0]                   db_count,
  output logic                               tx_req_valid,
  output logic [QUEUE_IDX_W-1:0]             tx_req_queue,
  input  logic                               tx_req_ready,
  input  logic                               tx_cpl_valid,
  input  logic [QUEUE_IDX_W-1:0]             tx_cpl_queue,
  input  logic                               tx_cpl_empty,
  output logic [QUEUES-1:0]                  queue_pending,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight_cnt,
  output logic                               cpl_err
);
  localparam int IC_W = $clog2(MAX_INFLIGHT + 1);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t                 state_q;
  logic [CNT_W-1:0]       pending_q [QUEUES];
  logic [CNT_W-1:0]       pending_d [QUEUES];
  logic [QUEUES-1:0]      inflight_q, inflight_d, cpl_hit, elig, pend_nz_d, queue_pending_q;
  logic [IC_W-1:0]        inflight_cnt_q, inflight_cnt_d;
  logic [QUEUE_IDX_W-1:0] rr_ptr_q, tx_req_queue_q, grant;
  logic                   tx_req_valid_q, cpl_err_q, grant_ok, hs, cpl_any;
  int                     j;
  assign hs = state_q == ISSUE && tx_req_ready;
  assign cpl_any = |cpl_hit;
  assign inflight_cnt_d = inflight_cnt_q + IC_W'(hs) - IC_W'(cpl_any);
  for (genvar i = 0; i < QUEUES; i++) begin : g_q
    logic             iss, dbh, clr;
    logic [CNT_W-1:0] base, add;
    logic [CNT_W:0]   sum;
    assign cpl_hit[i] = tx_cpl_valid && tx_cpl_queue == QUEUE_IDX_W'(i) && inflight_q[i];
    assign iss = hs && tx_req_queue_q == QUEUE_IDX_W'(i);
    assign dbh = db_valid && db_queue == QUEUE_IDX_W'(i);
    assign clr = cpl_hit[i] && tx_cpl_empty;
    // an empty completion resyncs to the ring: clear first, then add the doorbell
    assign base = clr ? '0 : pending_q[i];
    assign add = dbh ? db_count : '0;
    assign sum = {1'b0, base} + {1'b0, add} - {{CNT_W{1'b0}}, iss && !clr};
    assign pending_d[i] = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    assign pend_nz_d[i] = pending_d[i] != '0;
    assign inflight_d[i] = (inflight_q[i] && !cpl_hit[i]) || iss;
    assign elig[i] = enable[i] && pending_q[i] != '0 && !inflight_q[i] &&
                     inflight_cnt_q < IC_W'(MAX_INFLIGHT);
  end
  // scan downward so the last hit is the first eligible queue at or after rr_ptr
  always_comb begin
    grant_ok = 1'b0;
    grant = rr_ptr_q;
    j = 0;
    for (int k = QUEUES - 1; k >= 0; k--) begin
      j = int'(rr_ptr_q) + k;
      j = j >= QUEUES ? j - QUEUES : j;
      if (elig[j]) begin
        grant_ok = 1'b1;
        grant = QUEUE_IDX_W'(j);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      pending_q       <= '{default: '0};
      inflight_q      <= '0;
      inflight_cnt_q  <= '0;
      queue_pending_q <= '0;
      rr_ptr_q        <= '0;
      tx_req_valid_q  <= 1'b0;
      tx_req_queue_q  <= '0;
      cpl_err_q       <= 1'b0;
    end else begin
      pending_q       <= pending_d;
      inflight_q      <= inflight_d;
      inflight_cnt_q  <= inflight_cnt_d;
      queue_pending_q <= pend_nz_d;
      cpl_err_q       <= tx_cpl_valid && !cpl_any;
      case (state_q)
        IDLE: if (grant_ok) begin
          tx_req_valid_q <= 1'b1;
          tx_req_queue_q <= grant;
          state_q        <= ISSUE;
        end
        ISSUE: if (tx_req_ready) begin
          tx_req_valid_q <= 1'b0;
          rr_ptr_q       <= tx_req_queue_q == QUEUE_IDX_W'(QUEUES - 1) ? '0 : tx_req_queue_q + 1'b1;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign tx_req_valid  = tx_req_valid_q;
  assign tx_req_queue  = tx_req_queue_q;
  assign queue_pending = queue_pending_q;
  assign inflight_cnt  = inflight_cnt_q;
  assign cpl_err       = cpl_err_q;
endmodule

// File: tb/tb_cndm_proto_tx_sched.sv
// tb_cndm_proto_tx_sched: directed bench with an expected-grant scoreboard and
// optional auto-completion of issued requests after a fixed delay.
module tb_cndm_proto_tx_sched;
  logic        clk = 0, rst;
  logic [3:0]  enable;
  logic        db_valid, tx_req_ready, tx_cpl_valid, tx_cpl_empty;
  logic [1:0]  db_queue, tx_cpl_queue;
  logic [15:0] db_count;
  logic        tx_req_valid, cpl_err;
  logic [1:0]  tx_req_queue, inflight_cnt;
  logic [3:0]  queue_pending;
  cndm_proto_tx_sched dut (
    .clk(clk), .rst(rst), .enable(enable), .db_valid(db_valid), .db_queue(db_queue),
    .db_count(db_count), .tx_req_valid(tx_req_valid), .tx_req_queue(tx_req_queue),
    .tx_req_ready(tx_req_ready), .tx_cpl_valid(tx_cpl_valid), .tx_cpl_queue(tx_cpl_queue),
    .tx_cpl_empty(tx_cpl_empty), .queue_pending(queue_pending), .inflight_cnt(inflight_cnt),
    .cpl_err(cpl_err)
  );
  always #5 clk = ~clk;
  typedef struct {int due; logic [1:0] q;} cpl_t;
  logic [1:0] exp_q[$];
  cpl_t       sched[$];
  int         hs_cyc[$];
  int         checks = 0, passes = 0, cycle = 0, cpl_dly = 0, db_cycle = 0;
  logic       auto_cpl = 0, err_arm = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic db(input logic [1:0] q, input logic [15:0] n);
    db_valid = 1;
    db_queue = q;
    db_count = n;
  endtask
  task automatic cpl(input logic [1:0] q, input logic empty, input logic bogus);
    tx_cpl_valid = 1;
    tx_cpl_queue = q;
    tx_cpl_empty = empty;
    err_arm = bogus;
  endtask
  task automatic cyc();
    logic e;
    if (auto_cpl && !tx_cpl_valid && sched.size() > 0 && sched[0].due <= cycle) begin
      cpl(sched[0].q, 0, 0);
      void'(sched.pop_front());
    end
    if (!rst && tx_req_valid && tx_req_ready) begin
      hs_cyc.push_back(cycle);
      if (exp_q.size() == 0) chk("unexpected_grant", {30'd0, tx_req_queue}, 32'hFFFF_FFFF);
      else chk("grant_queue", {30'd0, tx_req_queue}, {30'd0, exp_q.pop_front()});
      if (auto_cpl) sched.push_back('{due: cycle + cpl_dly, q: tx_req_queue});
    end
    e = tx_cpl_valid && err_arm;
    @(negedge clk);
    cycle++;
    db_valid = 0;
    tx_cpl_valid = 0;
    tx_cpl_empty = 0;
    err_arm = 0;
    chk("cpl_err", {31'd0, cpl_err}, {31'd0, e});
  endtask
  task automatic drain(input int bound);
    for (int k = 0; k < bound && (exp_q.size() != 0 || sched.size() != 0); k++) cyc();
    chk("drain_left", exp_q.size() + sched.size(), 0);
  endtask
  task automatic wait_valid(input int bound);
    for (int k = 0; k < bound && !tx_req_valid; k++) cyc();
    chk("req_valid_wait", {31'd0, tx_req_valid}, 1);
  endtask
  initial begin
    rst = 1; enable = 4'hF; db_valid = 0; db_queue = 0; db_count = 0;
    tx_req_ready = 0; tx_cpl_valid = 0; tx_cpl_queue = 0; tx_cpl_empty = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, tx_req_valid}, 0);
    chk("rst_queue", {30'd0, tx_req_queue}, 0);
    chk("rst_pending", {28'd0, queue_pending}, 0);
    chk("rst_inflight", {30'd0, inflight_cnt}, 0);
    chk("rst_cpl_err", {31'd0, cpl_err}, 0);
    rst = 0;
    // 1: three requests on q2, each completed 5 cycles after it issues
    tx_req_ready = 1; auto_cpl = 1; cpl_dly = 5; hs_cyc.delete();
    exp_q = '{2'd2, 2'd2, 2'd2};
    db(2, 3); db_cycle = cycle; cyc();
    drain(60);
    chk("t1_hs_count", hs_cyc.size(), 3);
    chk("t1_db_to_hs", hs_cyc[0] - db_cycle, 2);
    chk("t1_gap1", hs_cyc[1] - hs_cyc[0], 7);
    chk("t1_gap2", hs_cyc[2] - hs_cyc[1], 7);
    chk("t1_pending", {28'd0, queue_pending}, 0);
    chk("t1_inflight", {30'd0, inflight_cnt}, 0);
    // 2: all four queues, round-robin with prompt completions
    cpl_dly = 1;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    for (int q = 0; q < 4; q++) begin db(2'(q), 2); cyc(); end
    drain(80);
    chk("t2_pending", {28'd0, queue_pending}, 0);
    chk("t2_inflight", {30'd0, inflight_cnt}, 0);
    // 3: in-flight limit holds further grants until a completion
    auto_cpl = 0;
    exp_q = '{2'd1, 2'd3};
    db(1, 5); cyc();
    db(3, 5); cyc();
    drain(20);
    for (int k = 0; k < 10; k++) cyc();
    chk("t3_inflight_full", {30'd0, inflight_cnt}, 2);
    chk("t3_stalled", {31'd0, tx_req_valid}, 0);
    exp_q.push_back(1);
    cpl(1, 0, 0); cyc();
    drain(20);
    chk("t3_inflight_again", {30'd0, inflight_cnt}, 2);
    cpl(1, 1, 0); cyc();
    cpl(3, 1, 0); cyc(); cyc();
    chk("t3_pending", {28'd0, queue_pending}, 0);
    chk("t3_inflight", {30'd0, inflight_cnt}, 0);
    // 4: empty completion resynchronises q0 to zero pending
    exp_q.push_back(0);
    db(0, 4); cyc();
    drain(20);
    chk("t4_pending_mid", {28'd0, queue_pending}, 4'b0001);
    cpl(0, 1, 0); cyc();
    for (int k = 0; k < 10; k++) cyc();
    chk("t4_pending", {28'd0, queue_pending}, 0);
    chk("t4_inflight", {30'd0, inflight_cnt}, 0);
    // 5: request held under backpressure; stray completions only pulse cpl_err
    tx_req_ready = 0;
    db(2, 1); cyc();
    wait_valid(10);
    chk("t5_queue", {30'd0, tx_req_queue}, 2);
    for (int k = 0; k < 10; k++) begin
      enable = enable ^ 4'b0101;
      if (k == 4) cpl(2, 1, 1);
      if (k == 6) cpl(1, 0, 1);
      cyc();
      chk("t5_hold_valid", {31'd0, tx_req_valid}, 1);
      chk("t5_hold_queue", {30'd0, tx_req_queue}, 2);
      chk("t5_inflight", {30'd0, inflight_cnt}, 0);
      chk("t5_pending", {28'd0, queue_pending}, 4'b0100);
    end
    enable = 4'hF; tx_req_ready = 1;
    exp_q.push_back(2);
    drain(5);
    cpl(2, 0, 0); cyc(); cyc();
    chk("t5_end_pending", {28'd0, queue_pending}, 0);
    chk("t5_end_inflight", {30'd0, inflight_cnt}, 0);
    // 6: saturation, then reset while a request is held
    tx_req_ready = 0; enable = 4'b1101;
    db(1, 16'hFFFF); cyc();
    db(1, 16'hFFFF); cyc(); cyc();
    chk("t6_sat", {16'd0, dut.pending_q[1]}, 32'hFFFF);
    db(1, 2); cyc(); cyc();
    chk("t6_sat_hold", {16'd0, dut.pending_q[1]}, 32'hFFFF);
    chk("t6_pending_flag", {28'd0, queue_pending}, 4'b0010);
    enable = 4'hF;
    wait_valid(10);
    chk("t6_queue", {30'd0, tx_req_queue}, 1);
    rst = 1; cyc(); rst = 0;
    chk("t6_rst_valid", {31'd0, tx_req_valid}, 0);
    chk("t6_rst_queue", {30'd0, tx_req_queue}, 0);
    chk("t6_rst_pending", {28'd0, queue_pending}, 0);
    chk("t6_rst_inflight", {30'd0, inflight_cnt}, 0);
    chk("t6_rst_cnt", {16'd0, dut.pending_q[1]}, 0);
    // 7: doorbell with handshake on one queue; handshake with completion together
    db(0, 1); cyc();
    wait_valid(10);
    chk("t7_queue0", {30'd0, tx_req_queue}, 0);
    tx_req_ready = 1; exp_q.push_back(0);
    db(0, 2); cyc();
    tx_req_ready = 0;
    chk("t7_db_and_issue", {16'd0, dut.pending_q[0]}, 2);
    chk("t7_inflight1", {30'd0, inflight_cnt}, 1);
    db(3, 1); cyc();
    wait_valid(10);
    chk("t7_queue3", {30'd0, tx_req_queue}, 3);
    tx_req_ready = 1; exp_q.push_back(3);
    cpl(0, 0, 0); cyc();
    tx_req_ready = 0;
    chk("t7_inflight_same", {30'd0, inflight_cnt}, 1);
    chk("t7_pending", {28'd0, queue_pending}, 4'b0001);
    wait_valid(10);
    chk("t7_regrant", {30'd0, tx_req_queue}, 0);
    chk("exp_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
